// File: rtl/fp_adder_seq.sv
// fp_adder_seq: feeds operand pairs to a fixed-latency, handshake-free pipelined adder and collects results in order.
// Latency: LAT+2 edges from the accept edge to out_valid (the accept edge counts as the first) with an empty result FIFO.
// Backpressure: in_ready drops while DEPTH ops are outstanding; results wait in the FIFO while out_ready=0.
// Optional feature: define FP_SEQ_CLASS_EN to store a 3-bit result class with each result and expose out_class.
module fp_adder_seq #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int LAT     = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [E_WIDTH+M_WIDTH:0]   in_a,
    input  logic [E_WIDTH+M_WIDTH:0]   in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [E_WIDTH+M_WIDTH:0]   out_res,
    output logic [E_WIDTH+M_WIDTH:0]   add_a,
    output logic [E_WIDTH+M_WIDTH:0]   add_b,
    input  logic [E_WIDTH+M_WIDTH:0]   add_res
`ifdef FP_SEQ_CLASS_EN
    ,
    output logic [2:0]                 out_class
`endif
);

    localparam int W  = 1 + E_WIDTH + M_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef FP_SEQ_CLASS_EN
    localparam int FW = W + 3;
`else
    localparam int FW = W;
`endif

    logic [W-1:0]  add_a_q, add_a_d;
    logic [W-1:0]  add_b_q, add_b_d;
    logic [LAT:0]  vld_q, vld_d;
    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] push_dat;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pending_q, pending_d;
    logic          accept;
    logic          push;
    logic          pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) r = '0;
        else                     r = p + PW'(1);
        return r;
    endfunction

`ifdef FP_SEQ_CLASS_EN
    // 0 normal/subnormal, 1 zero, 2 +inf, 3 -inf, 4 NaN.
    function automatic logic [2:0] classify(input logic [W-1:0] v);
        logic [E_WIDTH-1:0] e;
        logic [M_WIDTH-1:0] m;
        logic [2:0]         c;
        e = v[W-2 -: E_WIDTH];
        m = v[M_WIDTH-1:0];
        c = 3'd0;
        if (&e) begin
            if (m != '0)      c = 3'd4;
            else if (v[W-1])  c = 3'd3;
            else              c = 3'd2;
        end else if (e == '0 && m == '0) begin
            c = 3'd1;
        end
        return c;
    endfunction

    assign push_dat  = {classify(add_res), add_res};
    assign out_class = mem_q[rd_ptr_q][FW-1 -: 3];
`else
    assign push_dat  = add_res;
`endif

    // Credit check reads the registered counter only: a pop frees a slot one cycle later.
    assign in_ready  = (pending_q < CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = vld_q[LAT];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_res   = mem_q[rd_ptr_q][W-1:0];
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

    // Next-state for operand registers, valid pipeline, FIFO pointers and counters.
    always_comb begin
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        vld_d     = {vld_q[LAT-1:0], accept};
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (accept) begin
            add_a_d = in_a;
            add_b_d = in_b;
        end
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Control and operand state; reset also drops results still travelling through the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a_q   <= '0;
            add_b_q   <= '0;
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Result storage; the credit counter guarantees a push always finds a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: tb/tb_fp_adder_seq.sv
`timescale 1ns/1ps
module tb_fp_adder_seq;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  cls;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   b_acc[$];
    int   b_pop[$];

    // DUT A: DEPTH=4, DUT B: DEPTH=8, both LAT=3
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_a, a_in_b, a_out_res, a_add_a, a_add_b, a_add_res;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_a, b_in_b, b_out_res, b_add_a, b_add_b, b_add_res;
`ifdef FP_SEQ_CLASS_EN
    logic [2:0]  a_out_class, b_out_class;
`endif

    fp_adder_seq #(.E_WIDTH(8), .M_WIDTH(23), .LAT(LAT), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_a(a_in_a), .in_b(a_in_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_res(a_out_res),
        .add_a(a_add_a), .add_b(a_add_b), .add_res(a_add_res)
`ifdef FP_SEQ_CLASS_EN
        , .out_class(a_out_class)
`endif
    );

    fp_adder_seq #(.E_WIDTH(8), .M_WIDTH(23), .LAT(LAT), .DEPTH(8)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_a(b_in_a), .in_b(b_in_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res),
        .add_a(b_add_a), .add_b(b_add_b), .add_res(b_add_res)
`ifdef FP_SEQ_CLASS_EN
        , .out_class(b_out_class)
`endif
    );

    // Stand-in adder: a few fixed IEEE cases, otherwise an arbitrary scrambling function.
    function automatic logic [31:0] fmodel(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        if (x == 32'h3F800000 && y == 32'h7F800000) return 32'h7F800000;
        if (x == 32'h7F800000 && y == 32'hFF800000) return 32'h7FC00000;
        if (x == 32'h0 && y == 32'h0)               return 32'h0;
        return (x ^ {y[15:0], y[31:16]}) + 32'h01234567;
    endfunction

    function automatic logic [2:0] cls_of(input logic [31:0] v);
        if (v[30:23] == 8'hFF && v[22:0] != 23'd0) return 3'd4;
        if (v == 32'h7F800000) return 3'd2;
        if (v == 32'hFF800000) return 3'd3;
        if (v[30:0] == 31'd0)  return 3'd1;
        return 3'd0;
    endfunction

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        e.res = fmodel(x, y);
        e.cls = cls_of(e.res);
        return e;
    endfunction

    logic [31:0] spec_vals [6] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3F800000};
    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return spec_vals[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Adder models: result of the pair seen in cycle n appears during cycle n+LAT
    logic [31:0] pa [LAT];
    logic [31:0] pb [LAT];
    always @(posedge clk) begin
        pa[0] <= fmodel(a_add_a, a_add_b);
        pb[0] <= fmodel(b_add_a, b_add_b);
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign a_add_res = pa[LAT-1];
    assign b_add_res = pb[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the scoreboard whenever a result is taken
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected: got result %h, expected none", a_out_res);
            end else begin
                ea = qa.pop_front();
                check("a_res", a_out_res, ea.res);
`ifdef FP_SEQ_CLASS_EN
                check("a_class", 32'(a_out_class), 32'(ea.cls));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            b_pop.push_back(cyc);
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected: got result %h, expected none", b_out_res);
            end else begin
                eb = qb.pop_front();
                check("b_res", b_out_res, eb.res);
`ifdef FP_SEQ_CLASS_EN
                check("b_class", 32'(b_out_class), 32'(eb.cls));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send_a(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        a_in_valid = 1'b1; a_in_a = x; a_in_b = y;
        forever begin
            @(negedge clk);
            if (a_in_ready) break;
            n++;
            if (n >= 300) begin
                tests++; fails++;
                $display("FAIL a_send_timeout: in_ready stayed %b for %0d cycles, expected 1", a_in_ready, n);
                a_in_valid = 1'b0;
                return;
            end
        end
        qa.push_back(mk(x, y));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        b_in_valid = 1'b1; b_in_a = x; b_in_b = y;
        forever begin
            @(negedge clk);
            if (b_in_ready) break;
            n++;
            if (n >= 300) begin
                tests++; fails++;
                $display("FAIL b_send_timeout: in_ready stayed %b for %0d cycles, expected 1", b_in_ready, n);
                b_in_valid = 1'b0;
                return;
            end
        end
        qb.push_back(mk(x, y));
        b_acc.push_back(cyc + 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(qa.size() + qb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_out_ready = 1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_res", a_out_res, 32'd0);
        check("rst_add_a", a_add_a, 32'd0);
        check("rst_add_b", a_add_b, 32'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Offer a pair while reset is held: nothing may be accepted
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_a = 32'h3F800000; a_in_b = 32'h40000000; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_in_valid = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            check("rstpulse_out_valid", 32'(a_out_valid), 32'd0);
        end
        check("rstpulse_add_a", a_add_a, 32'd0);
        check("rstpulse_pending", 32'(u_a.pending_q), 32'd0);

        // Single op latency
        @(posedge clk); #1;
        send_a(32'h3F800000, 32'h40000000);
        check("single_add_a", a_add_a, 32'h3F800000);
        check("single_add_b", a_add_b, 32'h40000000);
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check("single_early_valid", 32'(a_out_valid), 32'd0);
        end
        @(negedge clk);
        check("single_valid", 32'(a_out_valid), 32'd1);
        check("single_res", a_out_res, 32'h40400000);
        drain("single_drain");

        // Back-pressure: 6 pairs offered with out_ready low
        a_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_a(rnd_op(), rnd_op());
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_accepted", 32'(qa.size()), 32'd4);
                check("bp_in_ready_low", 32'(a_in_ready), 32'd0);
                @(posedge clk); #1 a_out_ready = 1'b1;
                @(negedge clk);
                check("bp_ready_before_pop", 32'(a_in_ready), 32'd0);
                @(negedge clk);
                check("bp_ready_after_pop", 32'(a_in_ready), 32'd1);
            end
        join
        drain("bp_drain");

        // Randomized traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_a(rnd_op(), rnd_op());
                end
            end
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #1;
                    a_out_ready = ($urandom_range(0, 3) != 0);
                end
                a_out_ready = 1'b1;
            end
        join
        a_out_ready = 1'b1;
        drain("rand_drain");

        // Class cases and special values pass through
        send_a(32'h3F800000, 32'h7F800000);
        send_a(32'h7F800000, 32'hFF800000);
        send_a(32'h0, 32'h0);
        drain("class_drain");

        // Streaming on the DEPTH=8 instance
        for (int i = 0; i < 16; i++) send_b(rnd_op(), rnd_op());
        drain("stream_drain");
        check("stream_accepts", 32'(b_acc.size()), 32'd16);
        check("stream_pops", 32'(b_pop.size()), 32'd16);
        if (b_acc.size() == 16 && b_pop.size() == 16) begin
            check("stream_accept_span", 32'(b_acc[15] - b_acc[0]), 32'd15);
            check("stream_first_latency", 32'(b_pop[0] - b_acc[0]), 32'(LAT + 1));
            check("stream_pop_span", 32'(b_pop[15] - b_pop[0]), 32'd15);
        end

        // Reset with 3 ops in flight
        for (int i = 0; i < 3; i++) send_a(rnd_op(), rnd_op());
        rst = 1'b1;
        qa.delete();
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        end
        check("midrst_pending", 32'(u_a.pending_q), 32'd0);
        check("midrst_in_ready", 32'(a_in_ready), 32'd1);

        // First op after reset behaves as from cold
        @(posedge clk); #1;
        send_a(32'h3F800000, 32'h40000000);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
